// File: rtl/random_delay_gen.sv
// Random-delay timer for the reaction monitor: on entry to the wait state it latches MIN_MS plus
// an LFSR-derived offset, counts it in ms ticks and raises start_count. Macro FAST_SIM_EN selects
// a 1-cycle tick and a 4-bit random range for short simulations.
module random_delay_gen #(
  parameter int          TICK_DIV   = 100000,
  parameter int          MIN_MS     = 1000,
  parameter int          RANGE_BITS = 12,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  cen,
  output logic        start_count,
  output logic        led,
  output logic [15:0] delay_ms
);

  typedef enum logic [1:0] {
    CEN_IDLE  = 2'b00,
    CEN_WAIT  = 2'b01,
    CEN_REACT = 2'b10,
    CEN_DONE  = 2'b11
  } cen_e;

`ifdef FAST_SIM_EN
  localparam int RB = 4;
`else
  localparam int RB = RANGE_BITS;
`endif

  cen_e        cen_s;
  cen_e        cen_prev_q;
  logic        primed_q;
  logic [15:0] lfsr_q, lfsr_d;
  logic        lfsr_fb;
  logic [15:0] rand_ext;
  logic [15:0] ms_cnt_q, ms_cnt_d;
  logic [15:0] ms_inc;
  logic [15:0] delay_q, delay_d;
  logic        start_q, start_d;
  logic        armed_q, armed_d;
  logic        led_q;
  logic        wait_entry;
  logic        count_en;
  logic        tick;

  assign cen_s = cen_e'(cen);

  // primed_q masks the first cycle after reset so a cen already sitting in WAIT is not
  // mistaken for a fresh entry edge.
  assign wait_entry = primed_q && (cen_s == CEN_WAIT) && (cen_prev_q != CEN_WAIT);
  assign count_en   = armed_q && (cen_s == CEN_WAIT) && !start_q;

  // Fibonacci LFSR, taps 16,14,13,11.
  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign lfsr_d  = (lfsr_q == 16'h0000) ? LFSR_SEED : {lfsr_q[14:0], lfsr_fb};

  always_comb begin
    rand_ext         = '0;
    rand_ext[RB-1:0] = lfsr_q[RB-1:0];
  end

`ifdef FAST_SIM_EN
  assign tick = count_en;
`else
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;

  assign tick = count_en && (presc_q == PRE_LAST);

  always_comb begin
    presc_d = presc_q;
    if (wait_entry || (cen_s == CEN_IDLE)) begin
      presc_d = '0;
    end else if (count_en) begin
      presc_d = (presc_q == PRE_LAST) ? '0 : presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end
`endif

  assign ms_inc = ms_cnt_q + 16'd1;

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that skips an assignment
    // would otherwise infer a latch.
    delay_d  = delay_q;
    ms_cnt_d = ms_cnt_q;
    start_d  = start_q;
    armed_d  = armed_q;
    if (wait_entry) begin
      delay_d  = 16'(MIN_MS) + rand_ext;
      ms_cnt_d = '0;
      start_d  = 1'b0;
      armed_d  = 1'b1;
    end else if (cen_s == CEN_IDLE) begin
      ms_cnt_d = '0;
      start_d  = 1'b0;
      armed_d  = 1'b0;
    end else if (tick) begin
      ms_cnt_d = ms_inc;
      // >= rather than == so a zero-length delay still fires on the first tick.
      if (ms_inc >= delay_q) begin
        start_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every state register, including the LFSR, takes a defined value on reset; there is
    // no array storage here that could be left unreset.
    if (!rst_n) begin
      lfsr_q     <= LFSR_SEED;
      cen_prev_q <= CEN_IDLE;
      primed_q   <= 1'b0;
      ms_cnt_q   <= '0;
      delay_q    <= '0;
      start_q    <= 1'b0;
      armed_q    <= 1'b0;
      led_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      lfsr_q     <= lfsr_d;
      cen_prev_q <= cen_s;
      primed_q   <= 1'b1;
      ms_cnt_q   <= ms_cnt_d;
      delay_q    <= delay_d;
      start_q    <= start_d;
      armed_q    <= armed_d;
      led_q      <= (cen_s == CEN_REACT);
    end
  end

  assign start_count = start_q;
  assign led         = led_q;
  assign delay_ms    = delay_q;

endmodule

// File: tb/tb_random_delay_gen.sv
// Directed bench for random_delay_gen: expected delay and latency are pushed to a scoreboard at
// wait entry and popped when start_count rises. Honours FAST_SIM_EN when defined.
module tb_random_delay_gen;

  localparam int          TICK_DIV   = 4;
  localparam int          MIN_MS     = 3;
  localparam int          RANGE_BITS = 2;
  localparam logic [15:0] SEED       = 16'h0001;

`ifdef FAST_SIM_EN
  localparam int EFF_RB   = 4;
  localparam int EFF_TICK = 1;
  localparam int TARGET   = 9;
`else
  localparam int EFF_RB   = RANGE_BITS;
  localparam int EFF_TICK = TICK_DIV;
  localparam int TARGET   = 2;
`endif
  localparam int MAX_DELAY   = MIN_MS + (1 << EFF_RB) - 1;
  localparam int ABORT_CLKS  = (MIN_MS * EFF_TICK > 8) ? 8 : MIN_MS * EFF_TICK - 1;
  localparam int WAIT_BUDGET = 500;

  typedef struct {
    int delay;
    int latency;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [1:0]  cen;
  logic        start_count;
  logic        led;
  logic [15:0] delay_ms;
  logic [15:0] lfsr_m;

  int   checks;
  int   errors;
  exp_t sb_q[$];

  random_delay_gen #(
    .TICK_DIV  (TICK_DIV),
    .MIN_MS    (MIN_MS),
    .RANGE_BITS(RANGE_BITS),
    .LFSR_SEED (SEED)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cen        (cen),
    .start_count(start_count),
    .led        (led),
    .delay_ms   (delay_ms)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, reseeded if it ever hits zero.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_m <= SEED;
    else if (lfsr_m == 16'h0000) lfsr_m <= SEED;
    else lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic int model_delay();
    return MIN_MS + (int'(lfsr_m) & ((1 << EFF_RB) - 1));
  endfunction

  // Called at a negedge: the next posedge is the entry edge, latching the current lfsr value.
  task automatic enter_wait_tracked();
    exp_t e;
    e.delay   = model_delay();
    e.latency = e.delay * EFF_TICK + 1;
    sb_q.push_back(e);
    cen = 2'b01;
  endtask

  task automatic run_to_expiry(input string tag, output int seen_delay);
    int   lat;
    exp_t e;
    lat = 0;
    while (lat < WAIT_BUDGET && start_count !== 1'b1) begin
      @(negedge clk);
      lat++;
    end
    seen_delay = int'(delay_ms);
    check({tag, "_start_seen"}, 32'(start_count), 32'd1);
    check({tag, "_sb_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check({tag, "_delay"}, 32'(delay_ms), 32'(e.delay));
      check({tag, "_latency"}, 32'(lat), 32'(e.latency));
    end
  endtask

  initial begin
    int          n;
    int          d;
    int          seen;
    logic [31:0] val_mask;

    checks   = 0;
    errors   = 0;
    val_mask = '0;
    rst_n    = 1'b0;
    cen      = 2'b00;

    // 1: reset values, then no X after release.
    repeat (5) @(negedge clk);
    check("rst_start", 32'(start_count), 32'd0);
    check("rst_led", 32'(led), 32'd0);
    check("rst_delay", 32'(delay_ms), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_no_x", 32'((^{start_count, led, delay_ms}) !== 1'bx), 32'd1);
    check("post_rst_start", 32'(start_count), 32'd0);

    // 2: entry with a chosen random part, full count, hold, react, release.
    n = 0;
    while (n < 2000 && int'(lfsr_m[EFF_RB-1:0]) != TARGET) begin
      @(negedge clk);
      n++;
    end
    check("t2_target_found", 32'(int'(lfsr_m[EFF_RB-1:0])), 32'(TARGET));
    enter_wait_tracked();
    run_to_expiry("t2", d);
    check("t2_delay_fixed", 32'(d), 32'(MIN_MS + TARGET));
    repeat (10) @(negedge clk);
    check("t2_hold_wait", 32'(start_count), 32'd1);
    cen = 2'b10;
    @(negedge clk);
    check("t2_led_on", 32'(led), 32'd1);
    check("t2_hold_react", 32'(start_count), 32'd1);
    cen = 2'b11;
    @(negedge clk);
    check("t2_led_off_done", 32'(led), 32'd0);
    check("t2_hold_done", 32'(start_count), 32'd1);
    cen = 2'b00;
    @(negedge clk);
    check("t2_clear_start", 32'(start_count), 32'd0);
    check("t2_clear_led", 32'(led), 32'd0);

    // 3: abort before expiry, then re-entry latches a fresh delay.
    repeat (3) @(negedge clk);
    d   = model_delay();
    cen = 2'b01;
    repeat (ABORT_CLKS) @(negedge clk);
    check("t3_abort_delay", 32'(delay_ms), 32'(d));
    cen  = 2'b00;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (start_count === 1'b1) seen = 1;
    end
    check("t3_no_start", 32'(seen), 32'd0);
    check("t3_ms_cnt_clear", 32'(dut.ms_cnt_q), 32'd0);
    repeat (5) @(negedge clk);
    enter_wait_tracked();
    run_to_expiry("t3_reentry", d);
    cen = 2'b00;
    @(negedge clk);

    // 4: randomness over 16 trials with random idle gaps.
    for (int t = 0; t < 16; t++) begin
      repeat ($urandom_range(1, 7)) @(negedge clk);
      enter_wait_tracked();
      run_to_expiry("t4", d);
      check("t4_range", 32'(d >= MIN_MS && d <= MAX_DELAY), 32'd1);
      if (d >= 0 && d < 32) val_mask[d] = 1'b1;
      cen = 2'b00;
      @(negedge clk);
    end
    check("t4_distinct_ge3", 32'($countones(val_mask) >= 3), 32'd1);

    // 5: reset mid-count; release with cen held in WAIT must not start a count.
    repeat (2) @(negedge clk);
    cen = 2'b01;
    n   = 0;
    while (n < WAIT_BUDGET && dut.ms_cnt_q != 16'd2) begin
      @(negedge clk);
      n++;
    end
    check("t5_reached_ms2", 32'(dut.ms_cnt_q), 32'd2);
    rst_n = 1'b0;
    #1;
    check("t5_rst_start", 32'(start_count), 32'd0);
    check("t5_rst_led", 32'(led), 32'd0);
    check("t5_rst_delay", 32'(delay_ms), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    seen  = 0;
    repeat (60) begin
      @(negedge clk);
      if (start_count === 1'b1) seen = 1;
    end
    check("t5_no_start", 32'(seen), 32'd0);
    check("t5_delay_stays", 32'(delay_ms), 32'd0);

    // 7: REACT entered straight from IDLE runs no count.
    cen = 2'b00;
    repeat (3) @(negedge clk);
    cen = 2'b10;
    @(negedge clk);
    check("t7_led_direct", 32'(led), 32'd1);
    repeat (30) @(negedge clk);
    check("t7_no_start", 32'(start_count), 32'd0);
    cen = 2'b00;
    @(negedge clk);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
